alu_buf_exu: RTL and testbench
==============================

ALU_BUF_EXU -- requirements
Module: alu_buf_exu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (8..64).
REQ-002 Parameter TAG_W, default 5, physical-tag width.
REQ-003 Parameter ID_W, default 5, ROB instruction-id width.
REQ-004 Parameter DEPTH, default 2, result-buffer entries (1..8); CNT_W = $clog2(DEPTH+1).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 flush  input  1  squash; discards all buffered results.
REQ-008 in_req  input  1  reservation station offers an op.
REQ-009 in_rdy  output  1  unit accepts the op this cycle.
REQ-010 in_opc  input  4  operation code.
REQ-011 in_src1, in_src2  input  XLEN  operands.
REQ-012 in_tag  input  TAG_W  destination tag.
REQ-013 in_inst_id  input  ID_W  ROB id.
REQ-014 out_req  output  1  CDB result valid.
REQ-015 out_rdy  input  1  CDB grants the result.
REQ-016 out_tag, out_wdata, out_inst_id  output  TAG_W/XLEN/ID_W  head-entry result.
REQ-017 count  output  CNT_W  number of valid buffered results.

Function
REQ-018 Opcode map: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and; codes 10-15 SHALL produce result 0, no error.
REQ-019 Shifts use src2[$clog2(XLEN)-1:0] only; sra sign-fills; slt signed, sltu unsigned, result 1 or 0 zero-extended.
REQ-020 add/sub wrap modulo 2^XLEN; no overflow flag.
REQ-021 Push = in_req && in_rdy; pop = out_req && out_rdy.
REQ-022 Result, tag and inst_id computed combinationally and written into the FIFO tail on push edge.
REQ-023 Latency: op pushed into empty buffer at edge N SHALL present out_req=1 with its result from edge N onward (one cycle, no combinational in->out path).
REQ-024 Results leave in push order; out_* always reflect the head entry.
REQ-025 out_req = (count != 0); when count = 0, out_tag/out_wdata/out_inst_id SHALL be 0.
REQ-026 in_rdy = ~flush && ((count < DEPTH) || out_rdy); in_rdy SHALL NOT depend on in_req.
REQ-027 Simultaneous push and pop: count unchanged, pointers both advance; legal when full.
REQ-028 Head held stable (no change of out_*) while out_req=1 and out_rdy=0, unless flush.
REQ-029 Read/write pointers wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-030 flush=1 at an edge: count->0, pointers->0, push suppressed (in_rdy=0 that cycle); a pop in the same cycle is still considered taken by CDB but buffer ends empty.
REQ-031 count SHALL never exceed DEPTH nor underflow; push when full without pop cannot occur because in_rdy=0.

Reset
REQ-032 rst assertion immediately (asynchronously) forces count=0, pointers=0, out_req=0, out_tag/out_wdata/out_inst_id=0.
REQ-033 While rst=1, in_rdy=0; first push possible at the first edge after rst deasserts.
REQ-034 Reset mid-operation discards all buffered entries; no stale result reappears after release.
REQ-035 Storage array contents need not be reset; outputs SHALL still read 0 via REQ-025.

Verification
REQ-036 Basic ops, XLEN=32: sub src1=5 src2=7 -> out_wdata=0xFFFFFFFE; sra 0x80000000 by 0x24 -> 0xF8000000 (shamt 4); sltu 1 vs 0xFFFFFFFF -> 1; slt same -> 0; opc 12 -> 0.
REQ-037 Backpressure, DEPTH=2: out_rdy=0, push tags 3,4 -> count=2, in_rdy=0, out_tag=3 held; raise out_rdy -> tag 3 then 4 in consecutive cycles.
REQ-038 Full with simultaneous push/pop: count=2, out_rdy=1, push tag 9 -> count stays 2, order 3,4,9 preserved.
REQ-039 Flush: count=2, assert flush with in_req=1 -> next cycle count=0, out_req=0, offered op not accepted.
REQ-040 Async reset mid-burst: assert rst between edges with count=1 -> out_req=0 before next edge; after release, no result until new push.
REQ-041 DEPTH=3 wrap: 10 back-to-back push/pop with random stalls -> results match software model in order, count matches model each cycle.

Source files
------------

// File: rtl/alu_buf_exu_if.sv
// Issue/writeback channel between the reservation station, the ALU execution
// unit and the CDB arbiter. The slave modport is the execution unit's view.
interface alu_buf_exu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int ID_W  = 5,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_req;
  logic             in_rdy;
  logic [3:0]       in_opc;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic [ID_W-1:0]  in_inst_id;
  logic             out_req;
  logic             out_rdy;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_wdata;
  logic [ID_W-1:0]  out_inst_id;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_req, in_opc, in_src1, in_src2, in_tag, in_inst_id, out_rdy,
    input  in_rdy, out_req, out_tag, out_wdata, out_inst_id, count
  );

  modport slave (
    input  flush, in_req, in_opc, in_src1, in_src2, in_tag, in_inst_id, out_rdy,
    output in_rdy, out_req, out_tag, out_wdata, out_inst_id, count
  );
endinterface

// File: rtl/alu_buf_exu.sv
// Single-cycle integer ALU followed by a small result FIFO that holds results
// until the CDB grants them. Results leave strictly in issue order.
module alu_buf_exu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int ID_W  = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_buf_exu_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam int ENT_W = TAG_W + ID_W + XLEN;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [XLEN-1:0]  alu_res;
  logic [SH_W-1:0]  shamt;
  logic             in_rdy;
  logic             out_req;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign shamt = bus.in_src2[SH_W-1:0];

  // Combinational ALU; unused opcodes yield zero.
  always_comb begin
    alu_res = '0;
    case (bus.in_opc)
      4'd0: alu_res = bus.in_src1 + bus.in_src2;
      4'd1: alu_res = bus.in_src1 - bus.in_src2;
      4'd2: alu_res = bus.in_src1 << shamt;
      4'd3: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_src1) < $signed(bus.in_src2))};
      4'd4: alu_res = {{(XLEN-1){1'b0}}, (bus.in_src1 < bus.in_src2)};
      4'd5: alu_res = bus.in_src1 ^ bus.in_src2;
      4'd6: alu_res = bus.in_src1 >> shamt;
      4'd7: alu_res = $signed(bus.in_src1) >>> shamt;
      4'd8: alu_res = bus.in_src1 | bus.in_src2;
      4'd9: alu_res = bus.in_src1 & bus.in_src2;
      default: alu_res = '0;
    endcase
  end

  // Holding rst in in_rdy keeps pushes out until the first edge after release.
  assign in_rdy  = ~rst & ~bus.flush & ((count_q < CNT_W'(DEPTH)) | bus.out_rdy);
  assign out_req = (count_q != '0);
  assign push    = bus.in_req & in_rdy;
  assign pop     = out_req & bus.out_rdy;
  assign head    = mem_q[rptr_q];

  // Next-state for occupancy and pointers; flush empties the buffer outright.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (bus.flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Occupancy and pointer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Result storage; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.in_tag, bus.in_inst_id, alu_res};
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.out_req     = out_req;
  assign bus.count       = count_q;
  assign bus.out_tag     = out_req ? head[ENT_W-1 -: TAG_W]    : '0;
  assign bus.out_inst_id = out_req ? head[XLEN +: ID_W]        : '0;
  assign bus.out_wdata   = out_req ? head[XLEN-1:0]            : '0;
endmodule

// File: tb/tb_alu_buf_exu.sv
// Bench for alu_buf_exu: a DEPTH=2 and a DEPTH=3 instance share one stimulus
// stream; each is compared every cycle against a queue-based reference model.
module tb_alu_buf_exu;
  logic clk;
  logic rst;

  alu_buf_exu_if #(.XLEN(32), .TAG_W(5), .ID_W(5), .DEPTH(2)) if2 ();
  alu_buf_exu_if #(.XLEN(32), .TAG_W(5), .ID_W(5), .DEPTH(3)) if3 ();

  alu_buf_exu #(.XLEN(32), .TAG_W(5), .ID_W(5), .DEPTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  alu_buf_exu #(.XLEN(32), .TAG_W(5), .ID_W(5), .DEPTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  id;
    logic [31:0] data;
  } ent_t;

  ent_t mq [2][$];
  int   md [2] = '{2, 3};
  int   n_chk = 0;
  int   n_err = 0;

  logic        o_rdy [2];
  logic        o_req [2];
  logic [1:0]  o_cnt [2];
  logic [4:0]  o_tag [2];
  logic [4:0]  o_id  [2];
  logic [31:0] o_wd  [2];

  assign o_rdy[0] = if2.in_rdy;      assign o_rdy[1] = if3.in_rdy;
  assign o_req[0] = if2.out_req;     assign o_req[1] = if3.out_req;
  assign o_cnt[0] = if2.count;       assign o_cnt[1] = if3.count;
  assign o_tag[0] = if2.out_tag;     assign o_tag[1] = if3.out_tag;
  assign o_id[0]  = if2.out_inst_id; assign o_id[1]  = if3.out_inst_id;
  assign o_wd[0]  = if2.out_wdata;   assign o_wd[1]  = if3.out_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return 32'(int'(a) >>> sh);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Compare every output of both units against the model, then advance one edge.
  task automatic step(input logic rq, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tg, input logic [4:0] id,
                      input logic ordy, input logic fl);
    logic do_push [2];
    logic do_pop  [2];
    ent_t e;
    @(negedge clk);
    if2.in_req = rq;  if2.in_opc = op; if2.in_src1 = a; if2.in_src2 = b;
    if2.in_tag = tg;  if2.in_inst_id = id; if2.out_rdy = ordy; if2.flush = fl;
    if3.in_req = rq;  if3.in_opc = op; if3.in_src1 = a; if3.in_src2 = b;
    if3.in_tag = tg;  if3.in_inst_id = id; if3.out_rdy = ordy; if3.flush = fl;
    #1;
    for (int u = 0; u < 2; u++) begin
      int   sz;
      logic erdy;
      logic ereq;
      sz   = mq[u].size();
      ereq = (sz != 0);
      erdy = !rst && !fl && ((sz < md[u]) || ordy);
      chk($sformatf("u%0d_in_rdy", u), 64'(o_rdy[u]), 64'(erdy));
      chk($sformatf("u%0d_out_req", u), 64'(o_req[u]), 64'(ereq));
      chk($sformatf("u%0d_count", u), 64'(o_cnt[u]), 64'(sz));
      chk($sformatf("u%0d_out_tag", u), 64'(o_tag[u]), ereq ? 64'(mq[u][0].tag) : 64'd0);
      chk($sformatf("u%0d_out_id", u), 64'(o_id[u]), ereq ? 64'(mq[u][0].id) : 64'd0);
      chk($sformatf("u%0d_out_wdata", u), 64'(o_wd[u]), ereq ? 64'(mq[u][0].data) : 64'd0);
      do_push[u] = rq && erdy;
      do_pop[u]  = ereq && ordy;
    end
    e.tag  = tg;
    e.id   = id;
    e.data = ref_alu(op, a, b);
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (fl) mq[u].delete();
      else begin
        if (do_pop[u])  void'(mq[u].pop_front());
        if (do_push[u]) mq[u].push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 5'd0, ordy, 1'b0);
  endtask

  // Raise rst between edges and confirm outputs clear before the next edge.
  task automatic async_reset();
    if2.in_req = 1'b0; if3.in_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req2", 64'(if2.out_req), 64'd0);
    chk("arst_cnt2", 64'(if2.count), 64'd0);
    chk("arst_wd2", 64'(if2.out_wdata), 64'd0);
    chk("arst_req3", 64'(if3.out_req), 64'd0);
    chk("arst_tag3", 64'(if3.out_tag), 64'd0);
    mq[0].delete();
    mq[1].delete();
    step(1'b1, 4'd0, 32'd1, 32'd1, 5'd1, 5'd1, 1'b1, 1'b0);
    rst = 1'b0;
    idle(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    if2.in_req = 1'b0; if2.in_opc = '0; if2.in_src1 = '0; if2.in_src2 = '0;
    if2.in_tag = '0;   if2.in_inst_id = '0; if2.out_rdy = 1'b0; if2.flush = 1'b0;
    if3.in_req = 1'b0; if3.in_opc = '0; if3.in_src1 = '0; if3.in_src2 = '0;
    if3.in_tag = '0;   if3.in_inst_id = '0; if3.out_rdy = 1'b0; if3.flush = 1'b0;
    #2;
    chk("rst_out_req", 64'(if2.out_req), 64'd0);
    chk("rst_count", 64'(if2.count), 64'd0);
    chk("rst_in_rdy", 64'(if2.in_rdy), 64'd0);
    step(1'b1, 4'd0, 32'd1, 32'd2, 5'd1, 5'd1, 1'b1, 1'b0);
    rst = 1'b0;

    // Basic ops, each visible the cycle after its push.
    step(1'b1, 4'd1, 32'd5, 32'd7, 5'd1, 5'd1, 1'b1, 1'b0);
    chk("sub", 64'(if2.out_wdata), 64'hFFFF_FFFE);
    step(1'b1, 4'd7, 32'h8000_0000, 32'h24, 5'd2, 5'd2, 1'b1, 1'b0);
    chk("sra", 64'(if2.out_wdata), 64'hF800_0000);
    step(1'b1, 4'd4, 32'd1, 32'hFFFF_FFFF, 5'd3, 5'd3, 1'b1, 1'b0);
    chk("sltu", 64'(if2.out_wdata), 64'd1);
    step(1'b1, 4'd3, 32'd1, 32'hFFFF_FFFF, 5'd4, 5'd4, 1'b1, 1'b0);
    chk("slt", 64'(if2.out_wdata), 64'd0);
    step(1'b1, 4'd12, 32'd3, 32'd4, 5'd5, 5'd5, 1'b1, 1'b0);
    chk("opc12", 64'(if2.out_wdata), 64'd0);
    chk("opc12_tag", 64'(if2.out_tag), 64'd5);
    idle(1'b1);
    chk("drain_cnt", 64'(if2.count), 64'd0);

    // Backpressure, then full with simultaneous push and pop.
    step(1'b1, 4'd0, 32'd1, 32'd2, 5'd3, 5'd13, 1'b0, 1'b0);
    step(1'b1, 4'd0, 32'd3, 32'd4, 5'd4, 5'd14, 1'b0, 1'b0);
    chk("bp_cnt", 64'(if2.count), 64'd2);
    chk("bp_rdy", 64'(if2.in_rdy), 64'd0);
    chk("bp_tag", 64'(if2.out_tag), 64'd3);
    step(1'b1, 4'd0, 32'd5, 32'd6, 5'd9, 5'd19, 1'b1, 1'b0);
    chk("full_cnt", 64'(if2.count), 64'd2);
    chk("full_tag4", 64'(if2.out_tag), 64'd4);
    idle(1'b1);
    chk("full_tag9", 64'(if2.out_tag), 64'd9);
    idle(1'b1);
    idle(1'b1);

    // Flush while full and offering an op.
    step(1'b1, 4'd5, 32'd7, 32'd8, 5'd5, 5'd5, 1'b0, 1'b0);
    step(1'b1, 4'd8, 32'd7, 32'd8, 5'd6, 5'd6, 1'b0, 1'b0);
    step(1'b1, 4'd9, 32'd7, 32'd8, 5'd7, 5'd7, 1'b0, 1'b1);
    chk("flush_cnt", 64'(if2.count), 64'd0);
    chk("flush_req", 64'(if2.out_req), 64'd0);
    chk("flush_cnt3", 64'(if3.count), 64'd0);

    // Asynchronous reset with one result buffered.
    step(1'b1, 4'd2, 32'd1, 32'd3, 5'd8, 5'd8, 1'b0, 1'b0);
    async_reset();

    // Randomized traffic with stalls, flushes and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      if (i == 200) async_reset();
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b,
           5'($urandom), 5'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
